// File: rtl/spi_mult_master_if.sv
// Host request/response handshake and SPI pins of spi_mult_master, grouped as one bundle.
interface spi_mult_master_if;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 8;

  logic             start;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] product;
  logic             SCLK;
  logic             CS;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  start, a, b, MISO,
    output busy, done, product, SCLK, CS, MOSI
  );

  modport slave (
    output start, a, b, MISO,
    input  busy, done, product, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_mult_master.sv
// SPI master that ships {a,b} to a multiplier slave, waits GAP SCLK periods,
// then reads back the 8-bit product. All outputs are registered.
module spi_mult_master #(
  parameter int unsigned CLK_DIV = 5,
  parameter int unsigned GAP     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  spi_mult_master_if.master bus
);
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned NBITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SEND  = 3'd2,
    GAP_W = 3'd3,
    RECV  = 3'd4,
    FIN   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] product_q, product_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic active_c;
  logic tick_c;
  logic rise_c;
  logic fall_c;

  // Phases end on SCLK falling toggles (whole periods); data moves on rising toggles.
  assign active_c = (state_q == SETUP) || (state_q == SEND) ||
                    (state_q == GAP_W) || (state_q == RECV);
  assign tick_c   = active_c && (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_c   = tick_c && !sclk_q;
  assign fall_c   = tick_c && sclk_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      product_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      product_q <= product_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    product_d = product_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // SCLK divider only runs while a transfer phase is active
    if (active_c) begin
      if (tick_c) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
    end else begin
      div_d  = '0;
      sclk_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d    = {bus.a, bus.b};
          rx_d    = '0;
          cnt_d   = '0;
          div_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (fall_c) begin
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (rise_c) begin
          mosi_d = tx_q[WORD_W-1];
          tx_d   = {tx_q[WORD_W-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (fall_c && (cnt_q == CNT_W'(NBITS))) begin
          cnt_d   = '0;
          state_d = GAP_W;
        end
      end

      // Last data bit stays on MOSI until the first rising toggle of the gap
      GAP_W: begin
        if (rise_c) begin
          mosi_d = 1'b0;
        end else if (fall_c) begin
          if (cnt_q == CNT_W'(GAP - 1)) begin
            cnt_d   = '0;
            state_d = RECV;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RECV: begin
        if (rise_c) begin
          rx_d  = {rx_q[WORD_W-2:0], bus.MISO};
          cnt_d = cnt_q + CNT_W'(1);
        end else if (fall_c && (cnt_q == CNT_W'(NBITS))) begin
          product_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cs_d      = 1'b0;
          sclk_d    = 1'b0;
          div_d     = '0;
          cnt_d     = '0;
          state_d   = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.SCLK    = sclk_q;
  assign bus.CS      = cs_q;
  assign bus.MOSI    = mosi_q;
endmodule

// File: tb/tb_spi_mult_master.sv
// Scoreboard bench for spi_mult_master: default-parameter instance plus a CLK_DIV=2, GAP=1 instance,
// each talking to a behavioural SPI slave.
module tb_spi_mult_master;
  localparam int unsigned CD0 = 5;
  localparam int unsigned GP0 = 4;
  localparam int unsigned CD1 = 2;
  localparam int unsigned GP1 = 1;
  localparam int LAT0 = 212;
  localparam int LAT1 = 74;

  typedef struct {
    logic [7:0] prod;
    logic [7:0] mosi;
    int         t0;
    int         lat;
  } exp_t;

  logic CLK = 1'b0;
  logic rst0;
  logic rst1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  spi_mult_master_if sif0();
  spi_mult_master_if sif1();

  spi_mult_master #(.CLK_DIV(CD0), .GAP(GP0)) dut0 (.CLK(CLK), .RST(rst0), .bus(sif0.master));
  spi_mult_master #(.CLK_DIV(CD1), .GAP(GP1)) dut1 (.CLK(CLK), .RST(rst1), .bus(sif1.master));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave drives response bit for rising edge r; rising edges 10+gap..17+gap are the read phase.
  function automatic logic miso_bit(input int r, input int gap, input logic [7:0] resp);
    int idx;
    idx = 17 + gap - r;
    if (idx >= 0 && idx <= 7) return resp[3'(idx)];
    return 1'b0;
  endfunction

  int         rise0 = 0;
  int         rise1 = 0;
  logic [7:0] mcap0 = '0;
  logic [7:0] mcap1 = '0;
  logic [7:0] resp0 = '0;
  logic [7:0] resp1 = '0;
  logic       miso0 = 1'b0;
  logic       miso1 = 1'b0;

  assign sif0.MISO = miso0;
  assign sif1.MISO = miso1;

  always @(posedge sif0.SCLK or negedge sif0.SCLK or negedge sif0.CS) begin
    if (!sif0.CS) begin
      rise0 = 0;
      miso0 = 1'b0;
    end else if (sif0.SCLK) begin
      rise0 = rise0 + 1;
    end else begin
      if (rise0 >= 2 && rise0 <= 9) mcap0 = {mcap0[6:0], sif0.MOSI};
      miso0 = miso_bit(rise0 + 1, int'(GP0), resp0);
    end
  end

  always @(posedge sif1.SCLK or negedge sif1.SCLK or negedge sif1.CS) begin
    if (!sif1.CS) begin
      rise1 = 0;
      miso1 = 1'b0;
    end else if (sif1.SCLK) begin
      rise1 = rise1 + 1;
    end else begin
      if (rise1 >= 2 && rise1 <= 9) mcap1 = {mcap1[6:0], sif1.MOSI};
      miso1 = miso_bit(rise1 + 1, int'(GP1), resp1);
    end
  end

  // Monitor: pops the scoreboard on every done and tracks SCLK period
  logic done0_q = 1'b0;
  logic done1_q = 1'b0;
  logic sclk0_q = 1'b0;
  logic sclk1_q = 1'b0;
  int   lastr0 = -1;
  int   lastr1 = -1;
  exp_t e0;
  exp_t e1;

  always @(negedge CLK) begin
    if (sif0.done) begin
      chk("done0_width", int'(done0_q), 0);
      chk("done0_expected", int'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("product0", int'(sif0.product), int'(e0.prod));
        chk("mosi0", int'(mcap0), int'(e0.mosi));
        chk("latency0", cyc - e0.t0 + 1, e0.lat);
        chk("busy_at_done0", int'(sif0.busy), 0);
      end
    end
    if (sif1.done) begin
      chk("done1_width", int'(done1_q), 0);
      chk("done1_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("product1", int'(sif1.product), int'(e1.prod));
        chk("mosi1", int'(mcap1), int'(e1.mosi));
        chk("latency1", cyc - e1.t0 + 1, e1.lat);
        chk("busy_at_done1", int'(sif1.busy), 0);
      end
    end
    if (sif0.SCLK && !sclk0_q) begin
      if (lastr0 >= 0) chk("sclk_period0", cyc - lastr0, int'(2 * CD0));
      lastr0 = cyc;
    end
    if (sif1.SCLK && !sclk1_q) begin
      if (lastr1 >= 0) chk("sclk_period1", cyc - lastr1, int'(2 * CD1));
      lastr1 = cyc;
    end
    if (!sif0.CS) lastr0 = -1;
    if (!sif1.CS) lastr1 = -1;
    done0_q = sif0.done;
    done1_q = sif1.done;
    sclk0_q = sif0.SCLK;
    sclk1_q = sif1.SCLK;
  end

  task automatic issue0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] resp);
    exp_t e;
    resp0 = resp;
    sif0.a = a;
    sif0.b = b;
    sif0.start = 1'b1;
    e.prod = resp;
    e.mosi = {a, b};
    e.t0   = cyc;
    e.lat  = LAT0;
    q0.push_back(e);
    @(negedge CLK);
    sif0.start = 1'b0;
  endtask

  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [7:0] resp);
    exp_t e;
    resp1 = resp;
    sif1.a = a;
    sif1.b = b;
    sif1.start = 1'b1;
    e.prod = resp;
    e.mosi = {a, b};
    e.t0   = cyc;
    e.lat  = LAT1;
    q1.push_back(e);
    @(negedge CLK);
    sif1.start = 1'b0;
  endtask

  task automatic wait_done0(input int maxc);
    int n;
    n = 0;
    while (!sif0.done && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_done0", int'(sif0.done), 1);
  endtask

  task automatic wait_done1(input int maxc);
    int n;
    n = 0;
    while (!sif1.done && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_done1", int'(sif1.done), 1);
  endtask

  task automatic run0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] resp);
    issue0(a, b, resp);
    wait_done0(LAT0 + 20);
    @(negedge CLK);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic [7:0] resp);
    issue1(a, b, resp);
    wait_done1(LAT1 + 20);
    @(negedge CLK);
  endtask

  initial begin
    sif0.start = 1'b0; sif0.a = '0; sif0.b = '0;
    sif1.start = 1'b0; sif1.a = '0; sif1.b = '0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge CLK);

    // Start coinciding with reset must be dropped
    sif0.a = 4'hA; sif0.b = 4'h5; sif0.start = 1'b1;
    @(negedge CLK);
    rst0 = 1'b0; rst1 = 1'b0; sif0.start = 1'b0;
    @(negedge CLK);
    chk("rst_busy0", int'(sif0.busy), 0);
    chk("rst_done0", int'(sif0.done), 0);
    chk("rst_product0", int'(sif0.product), 0);
    chk("rst_sclk0", int'(sif0.SCLK), 0);
    chk("rst_cs0", int'(sif0.CS), 0);
    chk("rst_mosi0", int'(sif0.MOSI), 0);
    chk("rst_busy1", int'(sif1.busy), 0);
    chk("rst_cs1", int'(sif1.CS), 0);

    // Basic transactions
    run0(4'd1, 4'd6, 8'h06);
    run0(4'd15, 4'd15, 8'hE1);
    run0(4'd0, 4'd9, 8'h00);

    // Start during SEND is ignored
    issue0(4'd3, 4'd5, 8'h0F);
    repeat (40) @(negedge CLK);
    sif0.a = 4'd12; sif0.b = 4'd10; sif0.start = 1'b1;
    @(negedge CLK);
    sif0.start = 1'b0;
    chk("busy_after_ignored_start", int'(sif0.busy), 1);
    wait_done0(LAT0 + 20);
    repeat (30) @(negedge CLK);
    chk("idle_after_single_done", int'(sif0.busy), 0);

    // Abort during RECV
    resp0 = 8'h0E;
    sif0.a = 4'd2; sif0.b = 4'd7; sif0.start = 1'b1;
    @(negedge CLK);
    sif0.start = 1'b0;
    repeat (170) @(negedge CLK);
    rst0 = 1'b1;
    @(negedge CLK);
    chk("abort_cs", int'(sif0.CS), 0);
    chk("abort_sclk", int'(sif0.SCLK), 0);
    chk("abort_busy", int'(sif0.busy), 0);
    chk("abort_done", int'(sif0.done), 0);
    chk("abort_product", int'(sif0.product), 0);
    rst0 = 1'b0;
    repeat (60) @(negedge CLK);
    chk("abort_product_held", int'(sif0.product), 0);
    run0(4'd4, 4'd4, 8'h10);

    // Back-to-back: start in the done cycle is ignored, start in the next cycle accepted
    issue0(4'd5, 4'd3, 8'h0F);
    wait_done0(LAT0 + 20);
    sif0.a = 4'd9; sif0.b = 4'd9; sif0.start = 1'b1;
    @(negedge CLK);
    issue0(4'd6, 4'd7, 8'h2A);
    chk("restart_cs", int'(sif0.CS), 1);
    chk("restart_busy", int'(sif0.busy), 1);
    wait_done0(LAT0 + 20);
    @(negedge CLK);

    // Fast divider, single-period gap
    run1(4'd7, 4'd3, 8'h15);
    run1(4'd10, 4'd11, 8'h6E);

    repeat (20) @(negedge CLK);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
